// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  // x0 is hardwired to zero, so a load into it never creates a hazard
  localparam logic [REG_AW_DEFAULT-1:0] REG_X0 = '0;

  // Instruction word equivalent of the bubble loaded into ID/EX (addi x0,x0,0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear (has priority over inc_i)
//   inc_i        : add one unless already at all-ones
//   cnt_o        : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, data-memory wait freezes, saturating perf counters and a wait watchdog.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i    : source registers of the instruction in ID
//   ex_memread_i, ex_rd_i : load flag and destination of the instruction in EX
//   branch_taken_i        : branch in ID resolved taken
//   mem_req_i, mem_ready_i: MEM-stage access pending / completing
//   pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o :
//                           same-cycle (Mealy) pipeline controls
//   mem_timeout_o         : sticky watchdog flag
//   stall_cnt_o, flush_cnt_o : saturating cycle counts of stall / flush
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 64,
  parameter int unsigned REG_AW   = REG_AW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_write_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_freeze_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int unsigned WAIT_CNT_W = $clog2(WAIT_MAX + 1);

  state_e                state_q, state_d;
  logic                  memwait;
  logic                  loaduse;
  logic                  waiting;
  logic                  timeout_q;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign memwait = mem_req_i & ~mem_ready_i;
  assign loaduse = ex_memread_i & (ex_rd_i != REG_AW'(REG_X0)) &
                   ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and controls; freeze masks load-use and branch
  always_comb begin
    state_d       = state_q;
    waiting       = 1'b0;
    pc_write_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_i) begin
      ifid_flush_o = 1'b1;
      state_d      = RUN;
    end else begin
      // Once waiting, only the ready strobe releases the freeze
      waiting = (state_q == MEM_WAIT) ? ~mem_ready_i : memwait;
      if (waiting) begin
        pipe_freeze_o = 1'b1;
        ifid_stall_o  = 1'b1;
        state_d       = MEM_WAIT;
      end else begin
        state_d = RUN;
        if (loaduse) begin
          // Any simultaneous taken branch is re-resolved next cycle
          ifid_stall_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          pc_write_o   = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (ifid_stall_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

  // Consecutive frozen cycles; restarts whenever the freeze drops
  sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~pipe_freeze_o),
    .inc_i (pipe_freeze_o),
    .cnt_o (wait_cnt)
  );

  // Flag sets on the edge that brings the wait count to WAIT_MAX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else if (pipe_freeze_o && (wait_cnt >= WAIT_CNT_W'(WAIT_MAX - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with 4-bit perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 64;
  localparam int unsigned REG_AW   = 5;

  // Control vector order: {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] C_IDLE = 5'b10000;
  localparam logic [4:0] C_RST  = 5'b00100;
  localparam logic [4:0] C_LU   = 5'b01010;
  localparam logic [4:0] C_BR   = 5'b10100;
  localparam logic [4:0] C_FRZ  = 5'b01001;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic              ex_memread_i, branch_taken_i, mem_req_i, mem_ready_i;
  logic              pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o;
  logic              mem_timeout_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(
    .CNT_W    (CNT_W),
    .WAIT_MAX (WAIT_MAX),
    .REG_AW   (REG_AW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                       input logic [4:0] rd, input logic br, input logic req,
                       input logic rdy);
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    ex_memread_i   = mr;
    ex_rd_i        = rd;
    branch_taken_i = br;
    mem_req_i      = req;
    mem_ready_i    = rdy;
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    check(tag, 32'({pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o}),
          32'(exp));
    check({tag, "_excl"}, 32'(ifid_stall_o & ifid_flush_o), 32'd0);
  endtask

  task automatic chk_regs(input string tag, input int stall, input int flush, input logic tmo);
    check({tag, "_stall_cnt"}, 32'(stall_cnt_o), 32'(stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt_o), 32'(flush));
    check({tag, "_timeout"},   32'(mem_timeout_o), 32'(tmo));
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); #1;
    chk_ctrl("rst_ctrl", C_RST);

    @(negedge clk_i); rst_i = 1'b0; #1;
    chk_ctrl("idle", C_IDLE);
    chk_regs("post_rst", 0, 0, 1'b0);

    // Load-use on rs1: one stall cycle with bubble
    @(negedge clk_i); drive(5, 0, 1, 5, 0, 0, 0); #1;
    chk_ctrl("loaduse", C_LU);
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk_ctrl("after_lu", C_IDLE);
    check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Load into x0 never stalls
    @(negedge clk_i); drive(0, 0, 1, 0, 0, 0, 0); #1;
    chk_ctrl("load_x0", C_IDLE);

    // Taken branch alone flushes
    @(negedge clk_i); drive(0, 0, 0, 0, 1, 0, 0); #1;
    chk_ctrl("branch", C_BR);
    check("x0_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Load-use on rs2 together with branch: stall wins, no flush
    @(negedge clk_i); drive(1, 3, 1, 3, 1, 0, 0); #1;
    chk_ctrl("lu_plus_br", C_LU);
    check("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk_ctrl("after_lu_br", C_IDLE);
    chk_regs("lu_br", 2, 1, 1'b0);

    // Three wait cycles; branch and load-use are masked while frozen
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk_ctrl("mw1", C_FRZ);
    @(negedge clk_i); drive(0, 0, 0, 0, 1, 1, 0); #1;
    chk_ctrl("mw2_branch", C_FRZ);
    @(negedge clk_i); drive(5, 0, 1, 5, 0, 1, 0); #1;
    chk_ctrl("mw3_loaduse", C_FRZ);
    // Ready cycle evaluates like RUN: the branch flushes
    @(negedge clk_i); drive(0, 0, 0, 0, 1, 1, 1); #1;
    chk_ctrl("mw_ready_br", C_BR);
    // Back in RUN: no request and no ready must not freeze
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk_ctrl("run_after_mw", C_IDLE);
    chk_regs("mw", 5, 2, 1'b0);

    // Watchdog: hold the wait well past WAIT_MAX cycles
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk_ctrl("wd_start", C_FRZ);
    for (int k = 1; k <= int'(WAIT_MAX) + 5; k++) begin
      @(negedge clk_i); #1;
      if (k == int'(WAIT_MAX) - 1) check("wd_before", 32'(mem_timeout_o), 32'd0);
      if (k == int'(WAIT_MAX))     check("wd_at_max", 32'(mem_timeout_o), 32'd1);
    end
    chk_ctrl("wd_still_frozen", C_FRZ);
    chk_regs("wd_end", 15, 2, 1'b1);

    @(negedge clk_i); drive(0, 0, 0, 0, 0, 1, 1); #1;
    chk_ctrl("wd_release", C_IDLE);
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 0, 0); #1;
    check("wd_sticky", 32'(mem_timeout_o), 32'd1);

    // Reset in the middle of a wait
    @(negedge clk_i); drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk_ctrl("rw_frozen", C_FRZ);
    @(negedge clk_i); rst_i = 1'b1; #1;
    chk_ctrl("rst_midwait", C_RST);
    @(negedge clk_i); rst_i = 1'b0; drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk_ctrl("run_after_rst", C_IDLE);
    chk_regs("after_rst", 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the Stall/Flush inputs of the IF/ID register, the PC write enable, the ID/EX bubble insert and a global freeze for the later stages. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It also keeps saturating performance counters and a memory-wait watchdog.

Parameters:
CNT_W, 32, width of the stall and flush performance counters
WAIT_MAX, 64, consecutive memory-wait cycles after which mem_timeout_o is raised
REG_AW, 5, register-address width

Ports:
clk_i  in  1  single clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
id_rs1_i  in  REG_AW  rs1 of the instruction in ID
id_rs2_i  in  REG_AW  rs2 of the instruction in ID
ex_memread_i  in  1  the instruction in EX is a load
ex_rd_i  in  REG_AW  rd of the instruction in EX
branch_taken_i  in  1  branch in ID resolved taken this cycle
mem_req_i  in  1  the MEM stage holds a load/store accessing data memory
mem_ready_i  in  1  data memory completes the access this cycle
pc_write_o  out  1  PC register load enable
ifid_stall_o  out  1  to IF/ID Stall_i; hold contents
ifid_flush_o  out  1  to IF/ID Flush_i; zero contents
idex_bubble_o  out  1  load NOP control into ID/EX
pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
mem_timeout_o  out  1  sticky watchdog flag
stall_cnt_o  out  CNT_W  cycles with ifid_stall_o=1
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset effect: on a clock edge with rst_i=1, state becomes RUN, and both counters, the wait counter and mem_timeout_o are cleared.
- Outputs while rst_i=1: ifid_flush_o=1; pc_write_o=0; all other control outputs 0.
- Output timing: control outputs are combinational (Mealy) from the current state and inputs, so they act in the same cycle. Counters and the flag are registered.
- FSM states: RUN and MEM_WAIT.
- Memory condition: memwait = mem_req_i & ~mem_ready_i.
- Load-use condition: loaduse = ex_memread_i & (ex_rd_i != 0) & (ex_rd_i == id_rs1_i | ex_rd_i == id_rs2_i).
- Priority in RUN, highest first:
  1. memwait: pipe_freeze_o=1, ifid_stall_o=1, pc_write_o=0. Next state is MEM_WAIT.
  2. loaduse: ifid_stall_o=1, pc_write_o=0, idex_bubble_o=1. Exactly one cycle, because the bubble clears the condition. Stay in RUN.
  3. branch_taken_i: ifid_flush_o=1, pc_write_o=1 (PC takes the target).
  4. Otherwise pc_write_o=1 and all others 0.
- Load-use with a simultaneous taken branch: the flush is suppressed. The branch is re-resolved in the next cycle.
- MEM_WAIT: pipe_freeze_o=1, ifid_stall_o=1 and pc_write_o=0 while mem_ready_i=0.
- Leaving MEM_WAIT: in the cycle mem_ready_i=1, outputs are evaluated exactly as in RUN (load-use and branch allowed), and the next state is RUN.
- Freeze masking: loaduse and branch_taken_i are ignored while frozen.
- Stall/flush exclusivity: ifid_stall_o and ifid_flush_o are never 1 in the same cycle. A bench assertion checks this.
- Wait counter: counts frozen cycles due to memwait and resets to 0 when the freeze ends.
- Watchdog: when the wait counter reaches WAIT_MAX, mem_timeout_o sets and stays 1 until rst_i. The FSM keeps waiting; no forced exit.
- stall_cnt_o / flush_cnt_o: +1 on each cycle their signal is 1; saturate at 2^CNT_W-1, no wrap.
- Reset mid-wait: exits MEM_WAIT immediately and clears everything.

Decomposition:
- Shared package: state enum {RUN, MEM_WAIT}, REG_AW, the x0 register constant, and the NOP encoding used by ID/EX.
- One sub-module, sat_counter (parameterised width, inc, sync clear). It is instantiated twice, plus once for the wait counter with a compare.

Test Plan:
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 for one cycle -> ifid_stall_o=1, pc_write_o=0, idex_bubble_o=1 for exactly 1 cycle; stall_cnt_o=1.
- Load to x0: ex_rd_i=0, id_rs2_i=0, ex_memread_i=1 -> no stall, pc_write_o=1.
- Branch taken alone -> ifid_flush_o=1, pc_write_o=1, flush_cnt_o increments by 1. Load-use plus branch in the same cycle -> stall only, flush_cnt_o unchanged.
- mem_req_i=1 with mem_ready_i low for 3 cycles then high -> pipe_freeze_o=1 for 3 cycles, released in the ready cycle; state back to RUN next cycle; stall_cnt_o=3.
- mem_ready_i held 0 for WAIT_MAX+5 cycles -> mem_timeout_o rises after WAIT_MAX frozen cycles and stays 1. rst_i pulsed for 1 cycle -> flag 0, counters 0, state RUN.
- Branch in MEM_WAIT: branch_taken_i=1 during MEM_WAIT -> no flush. With CNT_W=4, 20 stall cycles -> stall_cnt_o saturates at 15.
